uart_sample_scheduler: RTL and testbench

- Shares one 8N1 UART transmitter between two 12-bit sample sources (ADC channel 0 and channel 1, e.g. FIR outputs).
- Holds one pending sample per channel and arbitrates round-robin between them.
- Serialises each granted sample into a fixed byte packet and sequences the transmitter through its act/busy handshake, one byte at a time.
- Sits between the sample datapath and the UART TX block.

---
 rtl/uart_sample_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_sample_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_scheduler.sv
// Round-robin two-channel 12-bit sample packetiser feeding an 8N1 UART TX act/busy handshake.
// Define UART_PKT_CHECKSUM_EN for 4-byte packets with an XOR trailer byte (3-byte packets otherwise).

module uart_sample_slot #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          grant_i,
  input  logic          clear_ovf_i,
  output logic          pending_o,
  output logic [DW-1:0] data_o,
  output logic          ovf_o
);
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] data_q, data_d;

  // A sample arriving on the grant cycle refills the slot; set beats clear on ovf.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    if (grant_i) pend_d = 1'b0;
    if (valid_i) begin
      if (!pend_q || grant_i) begin
        data_d = data_i;
        pend_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      data_q <= data_d;
    end
  end

  assign pending_o = pend_q;
  assign data_o    = data_q;
  assign ovf_o     = ovf_q;
endmodule

module uart_sample_scheduler #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s0_valid,
  input  logic [11:0] s0_data,
  input  logic        s1_valid,
  input  logic [11:0] s1_data,
  input  logic        clear_ovf,
  output logic        tx_act,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        pkt_done,
  output logic [1:0]  ovf,
  output logic        tx_err
);
  localparam int NUM_CH = 2;
  localparam int DW     = 12;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);
  localparam int         CW       = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          seq_q, seq_d;
  logic                last_grant_q;
  logic                pkt_ch_q;
  logic [DW-1:0]       pkt_samp_q;
  logic [7:0]          tx_data_q;
  logic                tx_err_q;
  logic                timeout, pkt_done_w;

  logic [NUM_CH-1:0]         valid_w, pend_w, grant_vec, ovf_w;
  logic [NUM_CH-1:0][DW-1:0] din_w, samp_w;
  logic                      grant_vld, grant_ch;

  assign valid_w = {s1_valid, s0_valid};
  assign din_w   = {s1_data, s0_data};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    uart_sample_slot #(.DW(DW)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_w[c]),
      .data_i     (din_w[c]),
      .grant_i    (grant_vec[c]),
      .clear_ovf_i(clear_ovf),
      .pending_o  (pend_w[c]),
      .data_o     (samp_w[c]),
      .ovf_o      (ovf_w[c])
    );
  end

  // Grant is also held off while tx_busy is high so a late busy from an aborted byte
  // can never overlap a fresh tx_act.
  always_comb begin
    grant_ch = pend_w[1];
    if (&pend_w) grant_ch = ~last_grant_q;
    grant_vld = (state_q == IDLE) && enable && !tx_busy && (|pend_w);
    grant_vec = '0;
    if (grant_vld) grant_vec[grant_ch] = 1'b1;
  end

  logic [7:0] b1_w, b2_w, byte_w;
  assign b1_w = {pkt_ch_q, seq_q, pkt_samp_q[11:8]};
  assign b2_w = pkt_samp_q[7:0];

  // Byte 0 is constant, so it is correct even on the grant edge before pkt_* update.
  always_comb begin
    byte_w = SYNC_BYTE;
    case (idx_d)
      2'd1:    byte_w = b1_w;
      2'd2:    byte_w = b2_w;
`ifdef UART_PKT_CHECKSUM_EN
      2'd3:    byte_w = SYNC_BYTE ^ b1_w ^ b2_w;
`endif
      default: byte_w = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    timeout    = 1'b0;
    pkt_done_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            pkt_done_w = 1'b1;
            seq_d      = seq_q + 3'd1;
            state_d    = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      seq_q        <= '0;
      last_grant_q <= 1'b1;
      pkt_ch_q     <= 1'b0;
      pkt_samp_q   <= '0;
      tx_data_q    <= '0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      tx_err_q <= timeout | (tx_err_q & ~clear_ovf);
      if (grant_vld) begin
        last_grant_q <= grant_ch;
        pkt_ch_q     <= grant_ch;
        pkt_samp_q   <= samp_w[grant_ch];
      end
      if (state_d == LOAD) tx_data_q <= byte_w;
    end
  end

  assign tx_act   = (state_q == LOAD);
  assign tx_data  = tx_data_q;
  assign pkt_done = pkt_done_w;
  assign ovf      = ovf_w;
  assign tx_err   = tx_err_q;
endmodule

// File: tb/tb_uart_sample_scheduler.sv
// Randomised scoreboard bench for uart_sample_scheduler with a 40-cycle busy TX model.
module tb_uart_sample_scheduler;
  localparam int ACK_TO = 16;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable, s0_valid, s1_valid, clear_ovf;
  logic [11:0] s0_data, s1_data;
  logic        tx_act, pkt_done, tx_err;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic [1:0]  ovf;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_sample_scheduler #(.SYNC_BYTE(8'hA5), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s0_valid(s0_valid), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_data(s1_data),
    .clear_ovf(clear_ovf), .tx_act(tx_act), .tx_data(tx_data),
    .tx_busy(tx_busy), .pkt_done(pkt_done), .ovf(ovf), .tx_err(tx_err)
  );

  // Transmitter model: busy one cycle after act, held for 40 cycles; noack suppresses it.
  bit noack = 1'b0;
  int busy_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_act && !noack) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 39;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: packet-level round robin, seq counter and byte layout.
  typedef struct { logic [7:0] b; bit last; } exp_t;
  exp_t expq[$];
  int exp_pkts = 0, seen_pkts = 0, act_cnt = 0;
  int mseq = 0, mlast = 1;
  bit last_popped = 1'b0;

  function automatic void push_pkt(int ch, logic [11:0] s, bit abort);
    exp_t e;
    logic [7:0] b1, b2;
    b1 = {ch[0], mseq[2:0], s[11:8]};
    b2 = s[7:0];
    mlast = ch;
    e.b = 8'hA5; e.last = 1'b0; expq.push_back(e);
    if (!abort) begin
      e.b = b1; e.last = 1'b0; expq.push_back(e);
      e.b = b2; e.last = (NB == 3); expq.push_back(e);
      if (NB == 4) begin
        e.b = 8'hA5 ^ b1 ^ b2; e.last = 1'b1; expq.push_back(e);
      end
      exp_pkts++;
      mseq = (mseq + 1) % 8;
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_act) begin
        exp_t e;
        act_cnt++;
        check("act_while_busy", {31'd0, tx_busy}, 32'd0);
        check("act_expected", {31'd0, expq.size() != 0}, 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e.b});
          last_popped = e.last;
        end
      end
      if (pkt_done) begin
        seen_pkts++;
        check("pkt_done_after_last_byte", {31'd0, last_popped}, 32'd1);
        last_popped = 1'b0;
      end
    end
  end

  task automatic drive(bit v0, logic [11:0] d0, bit v1, logic [11:0] d1, bit clr);
    @(posedge clk); #1;
    s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1; clear_ovf = clr;
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(expq.size() == 0 && seen_pkts == exp_pkts && !tx_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("idle_reached", {31'd0, n < 3000}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    expq.delete();
    exp_pkts = seen_pkts; mseq = 0; mlast = 1; last_popped = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base, basep, n, first;
    logic [11:0] a, b;
    enable = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; clear_ovf = 1'b0;
    s0_data = '0; s1_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_act", {31'd0, tx_act}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_ovf", {30'd0, ovf}, 32'd0);
    check("rst_tx_err", {31'd0, tx_err}, 32'd0);

    // single ch0 packet with k+2 latency
    base = act_cnt; basep = seen_pkts;
    push_pkt(0, 12'hABC, 1'b0);
    drive(1'b1, 12'hABC, 1'b0, 12'h0, 1'b0);
    @(negedge clk); check("lat_k1_no_act", {31'd0, tx_act}, 32'd0);
    @(negedge clk); check("lat_k2_act", {31'd0, tx_act}, 32'd1);
    wait_idle();
    check("act_count_one_pkt", act_cnt - base, NB);
    check("pkt_count_one_pkt", seen_pkts - basep, 1);

    // both pending after reset: ch0 first, then ch1 with seq 1
    do_reset();
    push_pkt(0, 12'hABC, 1'b0);
    push_pkt(1, 12'h123, 1'b0);
    drive(1'b1, 12'hABC, 1'b1, 12'h123, 1'b0);
    wait_idle();
    check("ovf_after_rr", {30'd0, ovf}, 32'd0);

    // overflow on ch0 while ch1 is in flight; set beats clear
    push_pkt(1, 12'h777, 1'b0);
    drive(1'b0, 12'h0, 1'b1, 12'h777, 1'b0);
    repeat (5) @(negedge clk);
    push_pkt(0, 12'h111, 1'b0);
    drive(1'b1, 12'h111, 1'b0, 12'h0, 1'b0);
    check("ovf_none_yet", {30'd0, ovf}, 32'd0);
    drive(1'b1, 12'h222, 1'b0, 12'h0, 1'b0);
    check("ovf_ch0_set", {30'd0, ovf}, 32'd1);
    drive(1'b1, 12'h333, 1'b0, 12'h0, 1'b1);
    check("ovf_set_wins", {30'd0, ovf}, 32'd1);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    check("ovf_cleared", {30'd0, ovf}, 32'd0);
    wait_idle();

    // handshake timeout: abort, tx_err, seq unchanged
    noack = 1'b1;
    a = 12'($urandom);
    push_pkt(0, a, 1'b1);
    drive(1'b1, a, 1'b0, 12'h0, 1'b0);
    n = 0;
    while (!tx_act && n < 10) begin @(negedge clk); n++; end
    check("to_act_seen", {31'd0, tx_act}, 32'd1);
    n = 0;
    while (!tx_err && n < 40) begin @(negedge clk); n++; end
    check("to_err_latency", {31'd0, (n >= ACK_TO && n <= ACK_TO + 2)}, 32'd1);
    check("to_err_set", {31'd0, tx_err}, 32'd1);
    noack = 1'b0;
    repeat (3) @(negedge clk);
    b = 12'($urandom);
    push_pkt(1, b, 1'b0);
    drive(1'b0, 12'h0, 1'b1, b, 1'b0);
    wait_idle();
    check("to_err_sticky", {31'd0, tx_err}, 32'd1);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    check("to_err_cleared", {31'd0, tx_err}, 32'd0);

    // enable dropped mid-packet, then a held sample resumes on enable
    a = 12'($urandom);
    base = act_cnt;
    push_pkt(0, a, 1'b0);
    drive(1'b1, a, 1'b0, 12'h0, 1'b0);
    n = 0;
    while (act_cnt < base + 2 && n < 500) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_idle();
    check("en_pkt_completed", act_cnt - base, NB);
    b = 12'($urandom);
    push_pkt(1, b, 1'b0);
    base = act_cnt;
    drive(1'b0, 12'h0, 1'b1, b, 1'b0);
    repeat (60) @(negedge clk);
    check("no_act_while_disabled", act_cnt - base, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    n = 0;
    while (!tx_act && n < 2) begin @(negedge clk); n++; end
    check("en_resume_within_2", {31'd0, tx_act}, 32'd1);
    wait_idle();

    // randomised traffic: single channels and simultaneous pairs
    for (int it = 0; it < 20; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      a = 12'($urandom); b = 12'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (mode == 0) begin
        push_pkt(0, a, 1'b0);
        drive(1'b1, a, 1'b0, 12'h0, 1'b0);
      end else if (mode == 1) begin
        push_pkt(1, b, 1'b0);
        drive(1'b0, 12'h0, 1'b1, b, 1'b0);
      end else begin
        first = (mlast == 1) ? 0 : 1;
        if (first == 0) begin
          push_pkt(0, a, 1'b0); push_pkt(1, b, 1'b0);
        end else begin
          push_pkt(1, b, 1'b0); push_pkt(0, a, 1'b0);
        end
        drive(1'b1, a, 1'b1, b, 1'b0);
      end
      wait_idle();
    end

    // nine ch0 packets: seq field 0..7 then wraps to 0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a = 12'($urandom);
      push_pkt(0, a, 1'b0);
      drive(1'b1, a, 1'b0, 12'h0, 1'b0);
      wait_idle();
    end

    // reset mid-packet with ch1 pending
    a = 12'($urandom);
    base = act_cnt;
    push_pkt(0, a, 1'b0);
    drive(1'b1, a, 1'b0, 12'h0, 1'b0);
    drive(1'b0, 12'h0, 1'b1, 12'h5A5, 1'b0);
    n = 0;
    while (act_cnt < base + 2 && n < 500) begin @(negedge clk); n++; end
    check("mid_rst_progress", {31'd0, act_cnt >= base + 2}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_act", {31'd0, tx_act}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_ovf", {30'd0, ovf}, 32'd0);
    expq.delete();
    exp_pkts = seen_pkts; mseq = 0; mlast = 1; last_popped = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = act_cnt;
    repeat (30) @(negedge clk);
    check("mid_rst_pending_lost", act_cnt - base, 0);

    check("queue_drained", expq.size(), 0);
    check("pkt_total", seen_pkts, exp_pkts);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
